// File: rtl/frontend_dispatch_rob_if.sv
// Host / scheduler / back-end bundle for frontend_dispatch_rob.
//   slave  : the front end's view. It receives requests, pops and completions, and drives the
//            bank heads and the host-side results.
//   master : the environment's view (host + schedulers + back end).
// Signals: in_* host request handshake, bank_* per-bank FIFO heads and pops,
//          done_* back-end completions, write_done/read_done/read_data/proto_err results.
interface frontend_dispatch_rob_if #(
  parameter int NUM_BANKS   = 16,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 26,
  parameter int ROB_ENTRIES = 64
);
  localparam int TAG_W = $clog2(ROB_ENTRIES);
  localparam int REQ_W = 1 + DATA_W + ADDR_W;

  logic                       in_valid;
  logic                       in_type;
  logic [DATA_W-1:0]          in_data;
  logic [ADDR_W-1:0]          in_addr;
  logic                       in_ready;
  logic [NUM_BANKS-1:0]       bank_valid;
  logic [NUM_BANKS*REQ_W-1:0] bank_req;
  logic [NUM_BANKS*TAG_W-1:0] bank_tag;
  logic [NUM_BANKS-1:0]       bank_pop;
  logic                       done_valid;
  logic                       done_type;
  logic [TAG_W-1:0]           done_tag;
  logic [DATA_W-1:0]          done_data;
  logic                       write_done;
  logic                       read_done;
  logic [DATA_W-1:0]          read_data;
  logic                       proto_err;

  modport slave (
    input  in_valid, in_type, in_data, in_addr, bank_pop,
           done_valid, done_type, done_tag, done_data,
    output in_ready, bank_valid, bank_req, bank_tag,
           write_done, read_done, read_data, proto_err
  );

  modport master (
    output in_valid, in_type, in_data, in_addr, bank_pop,
           done_valid, done_type, done_tag, done_data,
    input  in_ready, bank_valid, bank_req, bank_tag,
           write_done, read_done, read_data, proto_err
  );
endinterface

// File: rtl/frontend_dispatch_rob.sv
// Memory-controller request front end.
// Host requests are steered into per-bank FWFT FIFOs by the address bank field. Reads are
// tagged with a reorder-buffer slot. Read completions may arrive in any order and are
// returned to the host strictly in issue order, at most one per cycle.
// Ports: clk, rst (synchronous, active high), bus (frontend_dispatch_rob_if.slave).
module frontend_dispatch_rob #(
  parameter int NUM_BANKS   = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 26,
  parameter int BANK_LSB    = 0,
  parameter int ROB_ENTRIES = 64
) (
  input logic                    clk,
  input logic                    rst,
  frontend_dispatch_rob_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TAG_W  = $clog2(ROB_ENTRIES);
  localparam int REQ_W  = 1 + DATA_W + ADDR_W;
  localparam logic [TAG_W:0] ROB_FULL_CNT = (TAG_W+1)'(ROB_ENTRIES);

  // Bank FIFOs: one extra pointer bit separates full from empty.
  logic [REQ_W-1:0] fifo_mem_r [NUM_BANKS][FIFO_DEPTH];
  logic [TAG_W-1:0] fifo_tag_r [NUM_BANKS][FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_r   [NUM_BANKS];
  logic [PTR_W:0]   rd_ptr_r   [NUM_BANKS];
  logic [NUM_BANKS-1:0] full_s, empty_s, push_s, pop_s;
  logic             pop_err_s;
  logic [BANK_W-1:0] in_bank_s;
  logic             in_ready_s, accept_s;

  // Reorder buffer
  logic [TAG_W:0]   rob_head_r, rob_tail_r, rob_count_s;
  logic             rob_full_s;
  logic [ROB_ENTRIES-1:0] slot_valid_r;
  logic [DATA_W-1:0] slot_data_r [ROB_ENTRIES];
  logic [TAG_W-1:0] head_idx_s, tail_idx_s, done_dist_s;
  logic             done_ok_s, done_bad_s, retire_s;

  logic             write_done_r, read_done_r, proto_err_r;
  logic [DATA_W-1:0] read_data_r;

  // FIFO status, acceptance and per-bank push/pop decode
  always_comb begin
    pop_err_s   = 1'b0;
    in_bank_s   = bus.in_addr[BANK_LSB +: BANK_W];
    rob_count_s = rob_tail_r - rob_head_r;
    rob_full_s  = (rob_count_s == ROB_FULL_CNT);
    for (int g = 0; g < NUM_BANKS; g++) begin
      empty_s[g] = (wr_ptr_r[g] == rd_ptr_r[g]);
      full_s[g]  = (wr_ptr_r[g][PTR_W] != rd_ptr_r[g][PTR_W]) &&
                   (wr_ptr_r[g][PTR_W-1:0] == rd_ptr_r[g][PTR_W-1:0]);
    end
    // Full flags come from registered pointers only: a same-cycle pop never opens a full FIFO.
    in_ready_s = !rst && !full_s[in_bank_s] && (!bus.in_type || !rob_full_s);
    accept_s   = bus.in_valid && in_ready_s;
    for (int g = 0; g < NUM_BANKS; g++) begin
      push_s[g] = accept_s && (in_bank_s == BANK_W'(g));
      pop_s[g]  = bus.bank_pop[g] && !empty_s[g];
      if (bus.bank_pop[g] && empty_s[g]) begin
        pop_err_s = 1'b1;
      end else begin
        pop_err_s = pop_err_s;
      end
    end
  end

  // Completion validation and retire decision
  always_comb begin
    head_idx_s  = rob_head_r[TAG_W-1:0];
    tail_idx_s  = rob_tail_r[TAG_W-1:0];
    // Distance from head modulo ROB size; the tag is outstanding iff it is below the count.
    done_dist_s = bus.done_tag - head_idx_s;
    done_ok_s   = bus.done_valid && bus.done_type &&
                  ({1'b0, done_dist_s} < rob_count_s) && !slot_valid_r[bus.done_tag];
    done_bad_s  = bus.done_valid && bus.done_type && !done_ok_s;
    retire_s    = slot_valid_r[head_idx_s];
  end

  // FIFO pointer registers
  always_ff @(posedge clk) begin
    for (int g = 0; g < NUM_BANKS; g++) begin
      if (rst) begin
        wr_ptr_r[g] <= {(PTR_W+1){1'b0}};
        rd_ptr_r[g] <= {(PTR_W+1){1'b0}};
      end else begin
        if (push_s[g]) wr_ptr_r[g] <= wr_ptr_r[g] + 1'b1;
        if (pop_s[g])  rd_ptr_r[g] <= rd_ptr_r[g] + 1'b1;
      end
    end
  end

  // FIFO storage; reads carry their ROB tag, writes carry tag 0
  always_ff @(posedge clk) begin
    for (int g = 0; g < NUM_BANKS; g++) begin
      if (push_s[g]) begin
        fifo_mem_r[g][wr_ptr_r[g][PTR_W-1:0]] <= {bus.in_type, bus.in_addr, bus.in_data};
        fifo_tag_r[g][wr_ptr_r[g][PTR_W-1:0]] <= bus.in_type ? tail_idx_s : {TAG_W{1'b0}};
      end
    end
  end

  // ROB pointers and slot-valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      rob_head_r   <= {(TAG_W+1){1'b0}};
      rob_tail_r   <= {(TAG_W+1){1'b0}};
      slot_valid_r <= {ROB_ENTRIES{1'b0}};
    end else begin
      if (accept_s && bus.in_type) rob_tail_r <= rob_tail_r + 1'b1;
      // A completion needs a clear slot and a retire needs a set one, so they never hit the same slot.
      if (retire_s) begin
        rob_head_r               <= rob_head_r + 1'b1;
        slot_valid_r[head_idx_s] <= 1'b0;
      end
      if (done_ok_s) slot_valid_r[bus.done_tag] <= 1'b1;
    end
  end

  // ROB read-data storage
  always_ff @(posedge clk) begin
    if (done_ok_s) slot_data_r[bus.done_tag] <= bus.done_data;
  end

  // Registered host-side results
  always_ff @(posedge clk) begin
    if (rst) begin
      write_done_r <= 1'b0;
      read_done_r  <= 1'b0;
      read_data_r  <= {DATA_W{1'b0}};
      proto_err_r  <= 1'b0;
    end else begin
      write_done_r <= bus.done_valid && !bus.done_type;
      read_done_r  <= retire_s;
      read_data_r  <= retire_s ? slot_data_r[head_idx_s] : {DATA_W{1'b0}};
      proto_err_r  <= proto_err_r || pop_err_s || done_bad_s;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_head
    assign bus.bank_req[g*REQ_W +: REQ_W] = fifo_mem_r[g][rd_ptr_r[g][PTR_W-1:0]];
    assign bus.bank_tag[g*TAG_W +: TAG_W] = fifo_tag_r[g][rd_ptr_r[g][PTR_W-1:0]];
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.bank_valid = ~empty_s;
  assign bus.write_done = write_done_r;
  assign bus.read_done  = read_done_r;
  assign bus.read_data  = read_data_r;
  assign bus.proto_err  = proto_err_r;
endmodule
